// File: rtl/memkat_initiator.sv
// Known-answer memory test initiator: writes SEED^addr across BASE..LIMIT, reads it back,
// and reports pass/fail, mismatch count and the first failing address.
module memkat_initiator #(
    parameter logic [31:0] BASE  = 32'h0,
    parameter logic [31:0] LIMIT = 32'h4,
    parameter logic [31:0] STEP  = 32'd4,
    parameter logic [31:0] SEED  = 32'hA5A5_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] readdata,
    output logic [31:0] addr,
    output logic        memwrite,
    output logic        memread,
    output logic [31:0] writedata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [31:0] fail_addr
);

    typedef enum logic [2:0] {StIdle, StWr, StRd, StDrain, StFin} state_e;

    state_e      state;
    logic        cmp_valid;
    logic [31:0] cmp_exp;
    logic [31:0] cmp_addr;

    logic        mismatch;
    logic [7:0]  err_next;
    logic [31:0] fail_next;

    // Compare stage: readdata belongs to the read issued one cycle earlier.
    always_comb begin
        mismatch  = cmp_valid && (readdata != cmp_exp);
        err_next  = err_count;
        fail_next = fail_addr;
        if (mismatch) begin
            if (err_count != 8'hFF) begin
                err_next = err_count + 8'd1;
            end
            if (err_count == 8'd0) begin
                fail_next = cmp_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            addr      <= 32'h0;
            memwrite  <= 1'b0;
            memread   <= 1'b0;
            writedata <= 32'h0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 8'h0;
            fail_addr <= 32'h0;
            cmp_valid <= 1'b0;
            cmp_exp   <= 32'h0;
            cmp_addr  <= 32'h0;
        end else begin
            done      <= 1'b0;
            cmp_valid <= 1'b0;
            err_count <= err_next;
            fail_addr <= fail_next;
            unique case (state)
                StIdle: begin
                    memwrite <= 1'b0;
                    memread  <= 1'b0;
                    if (start) begin
                        pass      <= 1'b0;
                        err_count <= 8'h0;
                        fail_addr <= 32'h0;
                        addr      <= BASE;
                        writedata <= SEED ^ BASE;
                        memwrite  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= StWr;
                    end
                end
                StWr: begin
                    if (addr == LIMIT) begin
                        addr     <= BASE;
                        memwrite <= 1'b0;
                        memread  <= 1'b1;
                        state    <= StRd;
                    end else begin
                        addr      <= addr + STEP;
                        writedata <= SEED ^ (addr + STEP);
                    end
                end
                StRd: begin
                    cmp_valid <= 1'b1;
                    cmp_exp   <= SEED ^ addr;
                    cmp_addr  <= addr;
                    if (addr == LIMIT) begin
                        memread <= 1'b0;
                        state   <= StDrain;
                    end else begin
                        addr <= addr + STEP;
                    end
                end
                StDrain: begin
                    // The last compare lands on this edge, so judge from its result.
                    done  <= 1'b1;
                    pass  <= (err_next == 8'd0);
                    state <= StFin;
                end
                StFin: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_memkat_initiator.sv
// Self-checking bench: three instances (default window, 8-word window, 300-word window)
// with a behavioural memory and a reference model of the expected run outcome.
module tb_memkat_initiator;

    localparam logic [31:0] SEED = 32'hA5A5_0000;
    localparam logic [31:0] B_BASE = 32'h100;
    localparam logic [31:0] B_LIMIT = 32'h11C;
    localparam logic [31:0] C_BASE = 32'h1000;
    localparam logic [31:0] C_LIMIT = 32'h1000 + 32'd299 * 32'd4;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] starts;
    always #5 clk = ~clk;

    logic [31:0] rdata [3];
    logic [31:0] addr [3];
    logic [31:0] wdata [3];
    logic [31:0] faddr [3];
    logic [7:0]  errc [3];
    logic        mw [3], mr [3], busy [3], done [3], pass [3];

    memkat_initiator u_a (
        .clk(clk), .rst(rst), .start(starts[0]), .readdata(rdata[0]), .addr(addr[0]),
        .memwrite(mw[0]), .memread(mr[0]), .writedata(wdata[0]), .busy(busy[0]),
        .done(done[0]), .pass(pass[0]), .err_count(errc[0]), .fail_addr(faddr[0])
    );
    memkat_initiator #(.BASE(B_BASE), .LIMIT(B_LIMIT)) u_b (
        .clk(clk), .rst(rst), .start(starts[1]), .readdata(rdata[1]), .addr(addr[1]),
        .memwrite(mw[1]), .memread(mr[1]), .writedata(wdata[1]), .busy(busy[1]),
        .done(done[1]), .pass(pass[1]), .err_count(errc[1]), .fail_addr(faddr[1])
    );
    memkat_initiator #(.BASE(C_BASE), .LIMIT(C_LIMIT)) u_c (
        .clk(clk), .rst(rst), .start(starts[2]), .readdata(rdata[2]), .addr(addr[2]),
        .memwrite(mw[2]), .memread(mr[2]), .writedata(wdata[2]), .busy(busy[2]),
        .done(done[2]), .pass(pass[2]), .err_count(errc[2]), .fail_addr(faddr[2])
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory for instance A: two words, optional per-word read corruption mask.
    logic [31:0] mem_a [2];
    logic [31:0] mask_a [2];
    always @(posedge clk) begin
        if (mw[0]) mem_a[addr[0][2]] <= wdata[0];
        if (mr[0]) rdata[0] <= mem_a[addr[0][2]] ^ mask_a[addr[0][2]];
    end
    assign rdata[1] = 32'h0;
    assign rdata[2] = 32'h0;

    // Bus monitors
    logic [31:0] wa_q [3][$];
    logic [31:0] wd_q [3][$];
    logic [31:0] ra_q [3][$];
    int done_cnt [3];
    int done_cyc [3];
    int both_cnt = 0;
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (mw[i]) begin
                wa_q[i].push_back(addr[i]);
                wd_q[i].push_back(wdata[i]);
            end
            if (mr[i]) ra_q[i].push_back(addr[i]);
            if (mw[i] && mr[i]) both_cnt++;
            if (done[i]) begin
                done_cnt[i]++;
                done_cyc[i] = cyc;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mon(input int w);
        wa_q[w].delete();
        wd_q[w].delete();
        ra_q[w].delete();
        done_cnt[w] = 0;
    endtask

    // Pulse start for one cycle and wait for done; lat = done cycle minus E0, -1 on timeout.
    task automatic do_run(input int w, input int budget, output int lat);
        int e0;
        clear_mon(w);
        @(negedge clk);
        starts[w] = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        starts[w] = 1'b0;
        lat = -1;
        for (int k = 0; k < budget; k++) begin
            #1;
            if (done_cnt[w] > 0) begin
                lat = done_cyc[w] - e0;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Reference: N words from base by 4, expected pattern SEED^a, read data corrupted by mask.
    task automatic check_bus(input string tag, input int w, input logic [31:0] base, input int n);
        check({tag, " wr_count"}, wa_q[w].size(), n);
        check({tag, " rd_count"}, ra_q[w].size(), n);
        for (int i = 0; i < n && i < wa_q[w].size() && i < ra_q[w].size(); i++) begin
            check({tag, " wr_addr"}, wa_q[w][i], base + 32'(i) * 32'd4);
            check({tag, " wr_data"}, wd_q[w][i], SEED ^ (base + 32'(i) * 32'd4));
            check({tag, " rd_addr"}, ra_q[w][i], base + 32'(i) * 32'd4);
        end
    endtask

    typedef struct {
        logic [31:0] m0;
        logic [31:0] m1;
        logic        exp_pass;
        logic [7:0]  exp_err;
        logic [31:0] exp_fail;
    } vec_t;

    vec_t vecs [4];
    int lat;
    logic [7:0] m_err;
    logic [31:0] m_fail;

    initial begin
        vecs[0] = '{32'h0, 32'h0, 1'b1, 8'd0, 32'h0};
        vecs[1] = '{32'h0, 32'h1, 1'b0, 8'd1, 32'h4};
        vecs[2] = '{32'h1, 32'h0, 1'b0, 8'd1, 32'h0};
        vecs[3] = '{32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 8'd2, 32'h0};
        mask_a[0] = 32'h0;
        mask_a[1] = 32'h0;
        starts = 3'b000;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int w = 0; w < 3; w++) clear_mon(w);

        // Reset then idle
        repeat (10) @(negedge clk);
        #1;
        for (int w = 0; w < 3; w++) begin
            check("idle outputs", {addr[w], wdata[w], faddr[w]}, 96'h0);
            check("idle flags", {errc[w], mw[w], mr[w], busy[w], done[w], pass[w]}, 13'h0);
            check("idle strobes", wa_q[w].size() + ra_q[w].size() + done_cnt[w], 0);
        end

        // Table-driven runs on the default window
        for (int v = 0; v < 4; v++) begin
            mask_a[0] = vecs[v].m0;
            mask_a[1] = vecs[v].m1;
            do_run(0, 20, lat);
            check("tbl latency", 32'(lat), 32'd5);
            check("tbl pass", pass[0], vecs[v].exp_pass);
            check("tbl err_count", errc[0], vecs[v].exp_err);
            check("tbl fail_addr", faddr[0], vecs[v].exp_fail);
            check_bus("tbl", 0, 32'h0, 2);
            repeat (3) @(negedge clk);
            #1;
            check("tbl held", {pass[0], errc[0], faddr[0]}, {vecs[v].exp_pass, vecs[v].exp_err,
                                                          vecs[v].exp_fail});
            check("tbl idle", {busy[0], done[0], 32'(done_cnt[0])}, {2'b00, 32'd1});
        end

        // Start while busy: second pulse at E0+2 must be ignored
        mask_a[0] = 32'h0;
        mask_a[1] = 32'h0;
        clear_mon(0);
        @(negedge clk);
        starts[0] = 1'b1;
        lat = cyc + 1;
        @(negedge clk);
        starts[0] = 1'b0;
        @(negedge clk);
        starts[0] = 1'b1;
        @(negedge clk);
        starts[0] = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        check("busy done_cnt", done_cnt[0], 1);
        check("busy latency", 32'(done_cyc[0] - lat), 32'd5);
        check_bus("busy", 0, 32'h0, 2);
        check("busy pass", pass[0], 1'b1);

        // Reset during the first read cycle
        clear_mon(0);
        @(negedge clk);
        starts[0] = 1'b1;
        @(negedge clk);
        starts[0] = 1'b0;
        for (int k = 0; k < 10 && !mr[0]; k++) @(negedge clk);
        check("midrst in read", mr[0], 1'b1);
        #1 rst = 1'b1;
        #1;
        check("midrst outputs", {addr[0], wdata[0], faddr[0]}, 96'h0);
        check("midrst flags", {errc[0], mw[0], mr[0], busy[0], done[0], pass[0]}, 13'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("midrst no done", done_cnt[0], 0);
        check("midrst idle", {busy[0], mw[0], mr[0]}, 3'b000);
        do_run(0, 20, lat);
        check("midrst rerun latency", 32'(lat), 32'd5);
        check("midrst rerun pass", pass[0], 1'b1);
        check("midrst rerun err", errc[0], 8'd0);

        // Larger window, every read returns 0
        do_run(1, 40, lat);
        check("big latency", 32'(lat), 32'd17);
        check("big pass", pass[1], 1'b0);
        check("big err_count", errc[1], 8'd8);
        check("big fail_addr", faddr[1], B_BASE);
        check_bus("big", 1, B_BASE, 8);

        // 300-word window: error count saturates
        do_run(2, 700, lat);
        check("sat latency", 32'(lat), 32'd601);
        check("sat err_count", errc[2], 8'hFF);
        check("sat fail_addr", faddr[2], C_BASE);
        check("sat pass", pass[2], 1'b0);
        check("sat wr_count", wa_q[2].size(), 300);
        check("sat rd_count", ra_q[2].size(), 300);

        // Randomised corruption against the reference model
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 2; i++) begin
                mask_a[i] = ($urandom_range(0, 1) == 1) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
            end
            m_err = 8'd0;
            m_fail = 32'h0;
            for (int i = 0; i < 2; i++) begin
                if (mask_a[i] != 32'h0) begin
                    if (m_err == 8'd0) m_fail = 32'(i) * 32'd4;
                    m_err = m_err + 8'd1;
                end
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_run(0, 20, lat);
            check("rnd latency", 32'(lat), 32'd5);
            check("rnd err_count", errc[0], m_err);
            check("rnd fail_addr", faddr[0], m_fail);
            check("rnd pass", pass[0], m_err == 8'd0);
            check_bus("rnd", 0, 32'h0, 2);
            repeat (2) @(negedge clk);
        end

        check("no write+read overlap", both_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
